mitll_jtl_pulse_arbiter: RTL and testbench
==========================================

// Module: mitll_jtl_pulse_arbiter
// PURPOSE
//  Clocked scheduler sharing one JTL output line among N_REQ SFQ pulse sources.
//  Each source pulse is held in a one-quantum pending slot. Pending slots are granted round-robin.
//  At most one pulse reaches the shared line per grant. A GUARD-cycle recovery gap follows every emitted pulse.
//  Sits upstream of the merger/JTL chain. Keeps pulses on the shared line at least GUARD+1 cycles apart.
// PARAMETERS
//  N_REQ  4  number of requesting pulse sources (2..16)
//  GUARD  2  idle cycles forced after each emitted pulse (0..15)
//  CNT_W  8  width of emitted-pulse counter (stats option only)
// PORTS
//  clk         in   1              rising-edge clock
//  rst_n       in   1              synchronous reset, active-low
//  req_pulse   in   N_REQ          one-cycle request pulse per source
//  out_pulse   out  1              one-cycle pulse onto shared JTL line
//  out_src     out  $clog2(N_REQ)  index of source granted this out_pulse
//  pending     out  N_REQ          pending-slot state, one bit per source
//  busy        out  1              high in FIRE or GAP state
//  overflow    out  N_REQ          sticky: pulse lost, slot already full
//  pulse_count out  CNT_W          emitted-pulse count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n low at clk edge):
//   - pending, overflow, out_pulse, out_src, busy, pulse_count all cleared to 0
//   - rr pointer set to 0; state set to IDLE; gap counter cleared
//   - reset mid-operation drops all pending pulses and any pulse being fired
//  All outputs are registered.
//  Capture:
//   - req_pulse[i] high in cycle c sets pending[i], visible in c+1
//  Overflow:
//   - req_pulse[i] high while pending[i]=1 and i not granted that cycle
//   - pulse dropped; overflow[i] set and held until reset
//  Same-cycle request and grant on source i:
//   - pending[i] stays 1 (new pulse stored)
//   - no overflow
//  FSM states: IDLE, FIRE, GAP.
//  IDLE:
//   - if |pending, winner = first set bit at or above ptr, wrapping N_REQ-1 -> 0
//   - next cycle: state FIRE, out_pulse=1, out_src=winner, pending[winner] cleared
//   - ptr = (winner+1) mod N_REQ
//  FIRE (exactly 1 cycle):
//   - GUARD=0: state -> IDLE; next grant may fire in the very next cycle (back-to-back)
//   - GUARD>0: state -> GAP, counter = GUARD
//  GAP:
//   - out_pulse=0; counter decrements each cycle
//   - at counter==1 -> IDLE
//   - pending keeps capturing during GAP
//  Timing:
//   - min latency req_pulse -> out_pulse: 2 cycles
//   - min out_pulse spacing: GUARD+1 cycles
//  busy = (state != IDLE); out_src holds last winner when out_pulse=0.
// CONFIGURATION
//  JTL_ARB_STATS_EN defined:
//   - pulse_count increments on each out_pulse
//   - saturates at 2^CNT_W-1; cleared by reset
//  JTL_ARB_STATS_EN undefined:
//   - pulse_count tied to 0; no counter logic synthesized
// TESTING
//  1. Single source:
//     - stimulus: reset, then req_pulse=4'b0001 at cycle 3
//     - required: pending[0]=1 at c4; out_pulse=1, out_src=0 at c5; busy c5..c7; idle c8
//  2. Round-robin:
//     - stimulus: req_pulse=4'b1111 in one cycle, GUARD=2
//     - required: out_src sequence 0,1,2,3; out_pulse spaced exactly 3 cycles
//  3. Pointer wrap:
//     - stimulus: after a grant to src 3, req_pulse=4'b1001
//     - required: src 0 granted before src 3
//  4. Overflow:
//     - stimulus: req_pulse[2] twice while pending[2]=1 and in GAP
//     - required: overflow=4'b0100 sticky; only one out_pulse from src 2
//  5. Same-cycle request and grant:
//     - stimulus: req_pulse[1] in the cycle src 1 is granted
//     - required: pending[1] stays 1; overflow[1]=0; second out_pulse from src 1 follows
//  6. Reset mid-GAP, with JTL_ARB_STATS_EN:
//     - stimulus: reset during GAP with pending=4'b0110 and pulse_count=5
//     - required: all outputs 0 at the next cycle; no further out_pulse

Source files
------------

// File: rtl/mitll_jtl_pulse_arbiter_if.sv
// Handshake bundle for the shared-JTL pulse arbiter: request pulses in,
// emitted pulse, grant index, slot state and statistics out.
interface mitll_jtl_pulse_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
);
    localparam int SW = $clog2(N_REQ);

    logic [N_REQ-1:0] req_pulse;
    logic             out_pulse;
    logic [SW-1:0]    out_src;
    logic [N_REQ-1:0] pending;
    logic             busy;
    logic [N_REQ-1:0] overflow;
    logic [CNT_W-1:0] pulse_count;

    modport master (
        output req_pulse,
        input  out_pulse, out_src, pending, busy, overflow, pulse_count
    );

    modport slave (
        input  req_pulse,
        output out_pulse, out_src, pending, busy, overflow, pulse_count
    );
endinterface

// File: rtl/mitll_jtl_pulse_arbiter.sv
// Round-robin scheduler sharing one JTL line among N_REQ SFQ pulse sources.
// Define JTL_ARB_STATS_EN to build the saturating emitted-pulse counter.
module mitll_jtl_pulse_arbiter #(
    parameter int N_REQ = 4,
    parameter int GUARD = 2,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    mitll_jtl_pulse_arbiter_if.slave bus
);
    localparam int SW = $clog2(N_REQ);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FIRE = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [3:0] GUARD_V = 4'(GUARD);

    logic [1:0]       state;
    logic [3:0]       gap_cnt;
    logic [SW-1:0]    ptr;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] overflow;
    logic             out_pulse;
    logic [SW-1:0]    out_src;

    logic             ready;
    logic             found;
    logic             grant;
    logic [SW-1:0]    winner;
    logic [N_REQ-1:0] grant_mask;

    // A grant is decided in the last cycle before the line becomes free,
    // so consecutive pulses land exactly GUARD+1 cycles apart.
    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            FIRE:    ready = (GUARD == 0);
            GAP:     ready = (gap_cnt == 4'd1);
            default: ready = 1'b1;
        endcase
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && pending[(int'(ptr) + k) % N_REQ]) begin
                found  = 1'b1;
                winner = SW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        grant      = ready && found;
        grant_mask = '0;
        if (grant) grant_mask[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            ptr       <= '0;
            pending   <= '0;
            overflow  <= '0;
            out_pulse <= 1'b0;
            out_src   <= '0;
        end else begin
            pending   <= (pending & ~grant_mask) | bus.req_pulse;
            overflow  <= overflow | (bus.req_pulse & pending & ~grant_mask);
            out_pulse <= grant;
            if (grant) begin
                out_src <= winner;
                ptr     <= (winner == SW'(N_REQ - 1)) ? '0 : winner + 1'b1;
                state   <= FIRE;
                gap_cnt <= gap_cnt - 1'b1;
            end else begin
                case (state)
                    FIRE: begin
                        state   <= (GUARD == 0) ? IDLE : GAP;
                        gap_cnt <= GUARD_V;
                    end
                    GAP: begin
                        if (gap_cnt == 4'd1) state <= IDLE;
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef JTL_ARB_STATS_EN
    logic [CNT_W-1:0] pulse_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pulse_count <= '0;
        end else if (grant && (pulse_count != {CNT_W{1'b1}})) begin
            pulse_count <= pulse_count + 1'b1;
        end
    end

    assign bus.pulse_count = pulse_count;
`else
    assign bus.pulse_count = '0;
`endif

    assign bus.out_pulse = out_pulse;
    assign bus.out_src   = out_src;
    assign bus.pending   = pending;
    assign bus.overflow  = overflow;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mitll_jtl_pulse_arbiter.sv
// Bench for mitll_jtl_pulse_arbiter: directed scenarios plus random traffic,
// all checked against a timeline-based reference model.
module tb_mitll_jtl_pulse_arbiter;
    localparam int N  = 4;
    localparam int G  = 2;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mitll_jtl_pulse_arbiter_if #(.N_REQ(N), .CNT_W(CW)) bus ();

    mitll_jtl_pulse_arbiter #(
        .N_REQ(N),
        .GUARD(G),
        .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errs = 0;
    int checks = 0;
    int t = 0;

    logic [N-1:0] m_pend, m_ovf;
    int           m_ptr, m_last, m_src, m_cnt;
    logic         m_out;

    int pq_t[$];
    int pq_s[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     tag, got, exp, t);
        end
    endtask

    // Pulses may leave at most once per GUARD+1 cycles; the winner is the
    // first pending source scanning upward from the pointer.
    task automatic model_next(input logic [N-1:0] r, input logic rs);
        int w;
        logic [N-1:0] gm;
        if (!rs) begin
            m_pend = '0; m_ovf = '0; m_ptr = 0; m_last = -1000;
            m_out = 1'b0; m_src = 0; m_cnt = 0;
            return;
        end
        w = -1;
        if (m_pend != '0 && (t + 1) >= m_last + G + 1) begin
            for (int k = 0; k < N; k++)
                if (w < 0 && m_pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        gm = '0;
        if (w >= 0) gm[w] = 1'b1;
        m_ovf  = m_ovf | (r & m_pend & ~gm);
        m_pend = (m_pend & ~gm) | r;
        m_out  = (w >= 0);
        if (w >= 0) begin
            m_src  = w;
            m_ptr  = (w + 1) % N;
            m_last = t + 1;
`ifdef JTL_ARB_STATS_EN
            if (m_cnt != (1 << CW) - 1) m_cnt++;
`endif
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic rs = 1'b1);
        bus.req_pulse = r;
        rst_n = rs;
        model_next(r, rs);
        @(posedge clk);
        #1;
        t++;
        chk("out_pulse", 32'(bus.out_pulse), 32'(m_out));
        chk("out_src", 32'(bus.out_src), 32'(m_src));
        chk("pending", 32'(bus.pending), 32'(m_pend));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("busy", 32'(bus.busy), 32'((t - m_last) <= G));
        chk("pulse_count", 32'(bus.pulse_count), 32'(m_cnt));
        if (bus.out_pulse) begin
            pq_t.push_back(t);
            pq_s.push_back(int'(bus.out_src));
        end
    endtask

    task automatic do_reset();
        step('0, 1'b0);
        step('0, 1'b0);
        pq_t.delete();
        pq_s.delete();
    endtask

    int c0;
    int n2;
    logic [N-1:0] r;

    initial begin
        bus.req_pulse = '0;
        m_last = -1000;
        do_reset();

        // single source
        step('0); step('0);
        step(4'b0001);
        chk("t1_pend", 32'(bus.pending), 32'h1);
        step('0);
        chk("t1_fire", 32'(bus.out_pulse), 32'h1);
        chk("t1_src", 32'(bus.out_src), 32'h0);
        chk("t1_busy_a", 32'(bus.busy), 32'h1);
        step('0);
        chk("t1_busy_b", 32'(bus.busy), 32'h1);
        step('0);
        chk("t1_busy_c", 32'(bus.busy), 32'h1);
        step('0);
        chk("t1_idle", 32'(bus.busy), 32'h0);

        // round robin with exact GUARD+1 spacing
        do_reset();
        step(4'b1111);
        repeat (14) step('0);
        chk("t2_n", 32'(pq_s.size()), 32'd4);
        for (int i = 0; i < 4 && i < pq_s.size(); i++) begin
            chk("t2_src", 32'(pq_s[i]), 32'(i));
            if (i > 0) chk("t2_gap", 32'(pq_t[i] - pq_t[i-1]), 32'd3);
        end

        // pointer wrap after src 3
        pq_s.delete();
        step(4'b1001);
        repeat (8) step('0);
        chk("t3_n", 32'(pq_s.size()), 32'd2);
        if (pq_s.size() == 2) begin
            chk("t3_first", 32'(pq_s[0]), 32'd0);
            chk("t3_second", 32'(pq_s[1]), 32'd3);
        end

        // overflow on src 2 while its slot is full
        do_reset();
        step(4'b0101);
        step('0);
        step(4'b0100);
        step(4'b0100);
        repeat (10) step('0);
        chk("t4_ovf", 32'(bus.overflow), 32'h4);
        n2 = 0;
        foreach (pq_s[i]) if (pq_s[i] == 2) n2++;
        chk("t4_once", 32'(n2), 32'd1);

        // same-cycle request and grant on src 1
        do_reset();
        step(4'b0010);
        step(4'b0010);
        chk("t5_pend", 32'(bus.pending[1]), 32'h1);
        chk("t5_ovf", 32'(bus.overflow[1]), 32'h0);
        repeat (8) step('0);
        chk("t5_two", 32'(pq_s.size()), 32'd2);

        // reset in GAP with slots 1,2 pending and five pulses emitted
        do_reset();
        step(4'b1111);
        repeat (13) step('0);
        step(4'b0001);
        step('0);
        step(4'b0110);
        chk("t6_pend", 32'(bus.pending), 32'h6);
`ifdef JTL_ARB_STATS_EN
        chk("t6_cnt", 32'(bus.pulse_count), 32'd5);
`endif
        step('0, 1'b0);
        chk("t6_rst", {bus.out_pulse, bus.busy, 8'(bus.out_src),
                       8'(bus.pending), 8'(bus.overflow)}, 32'h0);
        chk("t6_rcnt", 32'(bus.pulse_count), 32'h0);
        c0 = pq_t.size();
        repeat (8) step('0);
        chk("t6_quiet", 32'(pq_t.size() - c0), 32'd0);

        // random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 3) == 0);
            step(r, ($urandom_range(0, 299) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
